// File: rtl/sat_pkg.sv
// Shared SAT clause encodings: per-variable value field and loader FSM states.
package sat_pkg;

  localparam logic [1:0] VAL_FREE = 2'b00;
  localparam logic [1:0] VAL_NEG  = 2'b01;
  localparam logic [1:0] VAL_POS  = 2'b10;
  localparam logic [1:0] VAL_CONF = 2'b11;

  localparam int VAR_FIELD_W = 3;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EMIT    = 2'd1,
    ST_DROP    = 2'd2
  } loader_state_t;

endpackage

// File: rtl/clause_loader_if.sv
// Literal stream in, clause-cell load bus out; master drives literals, slave is the loader.
interface clause_loader_if #(
  parameter int NUM_VARS = 8,
  parameter int IDX_W    = 3,
  parameter int LEN_W    = 5
);
  logic                    lit_valid_i;
  logic                    lit_ready_o;
  logic [IDX_W-1:0]        lit_var_i;
  logic                    lit_pol_i;
  logic                    lit_last_i;
  logic                    abort_i;
  logic                    wr_o;
  logic [NUM_VARS*3-1:0]   var_value_o;
  logic [LEN_W-1:0]        clause_len_o;

  modport master (
    output lit_valid_i, lit_var_i, lit_pol_i, lit_last_i, abort_i,
    input  lit_ready_o, wr_o, var_value_o, clause_len_o
  );

  modport slave (
    input  lit_valid_i, lit_var_i, lit_pol_i, lit_last_i, abort_i,
    output lit_ready_o, wr_o, var_value_o, clause_len_o
  );
endinterface

// File: rtl/lit_slot_update.sv
// Folds one literal into a single variable slot: fills an empty slot, ignores a repeat,
// flags a tautology when the opposite polarity is already present.
module lit_slot_update
  import sat_pkg::*;
(
  input  logic [VAR_FIELD_W-1:0] slot_i,
  input  logic                   pol_i,
  input  logic                   hit_i,
  output logic [VAR_FIELD_W-1:0] slot_o,
  output logic                   inc_len_o,
  output logic                   taut_o
);
  logic [1:0] w_want;

  assign w_want = pol_i ? VAL_POS : VAL_NEG;

  always_comb begin
    slot_o    = slot_i;
    inc_len_o = 1'b0;
    taut_o    = 1'b0;
    if (hit_i) begin
      if (slot_i[2:1] == VAL_FREE) begin
        slot_o    = {w_want, 1'b0};
        inc_len_o = 1'b1;
      end else if (slot_i[2:1] != w_want) begin
        taut_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/clause_loader.sv
// Assembles a serial literal stream into a clause-cell write, dropping tautological
// or out-of-range clauses and counting successful loads.
module clause_loader
  import sat_pkg::*;
#(
  parameter int NUM_VARS = 8,
  parameter int IDX_W    = 3,
  parameter int LEN_W    = 5,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  clause_loader_if.slave    bus,
  output logic              taut_o,
  output logic              range_err_o,
  output logic [CNT_W-1:0]  clause_cnt_o
);
  localparam int VEC_W = NUM_VARS * VAR_FIELD_W;

  loader_state_t    r_state, w_state_next;
  logic [VEC_W-1:0] r_buf, w_buf_next, w_slot_new;
  logic [LEN_W-1:0] r_len, w_len_next;
  logic             r_taut, w_taut_next;
  logic             r_range, w_range_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_rdy_en;

  logic                w_ready, w_xfer, w_range;
  logic [NUM_VARS-1:0] w_hit, w_inc, w_taut;

  assign w_ready = r_rdy_en && (r_state == ST_COLLECT);
  assign w_xfer  = bus.lit_valid_i && w_ready;
  assign w_range = (32'(bus.lit_var_i) >= NUM_VARS);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VARS; gi++) begin : g_slot
      assign w_hit[gi] = w_xfer && !bus.abort_i && (bus.lit_var_i == IDX_W'(gi));
      lit_slot_update u_slot (
        .slot_i    (r_buf[gi*VAR_FIELD_W +: VAR_FIELD_W]),
        .pol_i     (bus.lit_pol_i),
        .hit_i     (w_hit[gi]),
        .slot_o    (w_slot_new[gi*VAR_FIELD_W +: VAR_FIELD_W]),
        .inc_len_o (w_inc[gi]),
        .taut_o    (w_taut[gi])
      );
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_buf_next   = r_buf;
    w_len_next   = r_len;
    w_taut_next  = r_taut;
    w_range_next = r_range;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      ST_COLLECT: begin
        if (bus.abort_i) begin
          w_buf_next   = '0;
          w_len_next   = '0;
          w_taut_next  = 1'b0;
          w_range_next = 1'b0;
        end else if (w_xfer) begin
          w_buf_next   = w_slot_new;
          w_len_next   = r_len + LEN_W'(|w_inc);
          w_taut_next  = r_taut | (|w_taut);
          w_range_next = r_range | w_range;
          // The flags include this literal, so a bad last literal also drops the clause.
          if (bus.lit_last_i)
            w_state_next = (w_taut_next || w_range_next) ? ST_DROP : ST_EMIT;
        end
      end
      ST_EMIT, ST_DROP: begin
        if (r_state == ST_EMIT) w_cnt_next = r_cnt + 1'b1;
        w_buf_next   = '0;
        w_len_next   = '0;
        w_taut_next  = 1'b0;
        w_range_next = 1'b0;
        w_state_next = ST_COLLECT;
      end
      default: w_state_next = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_COLLECT;
      r_buf    <= '0;
      r_len    <= '0;
      r_taut   <= 1'b0;
      r_range  <= 1'b0;
      r_cnt    <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_buf    <= w_buf_next;
      r_len    <= w_len_next;
      r_taut   <= w_taut_next;
      r_range  <= w_range_next;
      r_cnt    <= w_cnt_next;
      r_rdy_en <= 1'b1;
    end
  end

  assign bus.lit_ready_o  = w_ready;
  assign bus.wr_o         = (r_state == ST_EMIT);
  assign bus.var_value_o  = r_buf;
  assign bus.clause_len_o = r_len;
  assign taut_o           = (r_state == ST_DROP) && r_taut;
  assign range_err_o      = (r_state == ST_DROP) && r_range;
  assign clause_cnt_o     = r_cnt;
endmodule

// File: tb/tb_clause_loader.sv
// Directed plus random clause streams checked against a set-based clause model;
// a narrow counter keeps the wrap test short.
module tb_clause_loader;
  localparam int NV = 8;
  localparam int IW = 4;
  localparam int LW = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          taut, rerr;
  logic [CW-1:0] cnt;

  clause_loader_if #(.NUM_VARS(NV), .IDX_W(IW), .LEN_W(LW)) lif ();

  clause_loader #(.NUM_VARS(NV), .IDX_W(IW), .LEN_W(LW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (lif.slave),
    .taut_o       (taut),
    .range_err_o  (rerr),
    .clause_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  int cl_n;
  int cl_var[16];
  bit cl_pol[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    lif.lit_valid_i = 1'b0;
    lif.lit_var_i   = '0;
    lif.lit_pol_i   = 1'b0;
    lif.lit_last_i  = 1'b0;
    lif.abort_i     = 1'b0;
  endtask

  // Entered and left on a negedge; the literal is taken at the posedge in between.
  task automatic send(input int v, input bit p, input bit l);
    int n;
    n = 0;
    lif.lit_valid_i = 1'b1;
    lif.lit_var_i   = IW'(v);
    lif.lit_pol_i   = p;
    lif.lit_last_i  = l;
    lif.abort_i     = 1'b0;
    while (lif.lit_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(lif.lit_ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic run_clause();
    int          pol_of[16];
    int          e_len;
    bit          e_taut, e_range;
    logic [31:0] e_vec;
    e_len = 0; e_taut = 0; e_range = 0; e_vec = 0;
    for (int i = 0; i < 16; i++) pol_of[i] = -1;
    for (int i = 0; i < cl_n; i++) begin
      if (cl_var[i] >= NV) e_range = 1;
      else if (pol_of[cl_var[i]] < 0) begin
        pol_of[cl_var[i]] = int'(cl_pol[i]);
        e_len++;
      end else if (pol_of[cl_var[i]] != int'(cl_pol[i])) e_taut = 1;
    end
    for (int v = 0; v < NV; v++)
      if (pol_of[v] >= 0) e_vec |= (pol_of[v] == 1 ? 32'h4 : 32'h2) << (v * 3);
    for (int i = 0; i < cl_n; i++) send(cl_var[i], cl_pol[i], i == cl_n - 1);
    $display("clause lits=%0d exp_len=%0d taut=%0d range=%0d", cl_n, e_len, e_taut, e_range);
    if (!e_taut && !e_range) begin
      chk("emit_wr", 32'(lif.wr_o), 32'd1);
      chk("emit_vec", 32'(lif.var_value_o), e_vec);
      chk("emit_len", 32'(lif.clause_len_o), 32'(e_len));
      chk("emit_ready", 32'(lif.lit_ready_o), 32'd0);
      exp_cnt = (exp_cnt + 1) % (1 << CW);
    end else begin
      chk("drop_wr", 32'(lif.wr_o), 32'd0);
      chk("drop_taut", 32'(taut), 32'(e_taut));
      chk("drop_range", 32'(rerr), 32'(e_range));
    end
    @(negedge clk);
    chk("post_wr", 32'(lif.wr_o), 32'd0);
    chk("post_cnt", 32'(cnt), 32'(exp_cnt));
    chk("post_flags", 32'({taut, rerr}), 32'd0);
  endtask

  initial begin
    int start_cnt;
    idle();
    repeat (3) @(negedge clk);
    chk("rst_wr", 32'(lif.wr_o), 32'd0);
    chk("rst_vec", 32'(lif.var_value_o), 32'd0);
    chk("rst_len", 32'(lif.clause_len_o), 32'd0);
    chk("rst_flags", 32'({taut, rerr}), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(lif.lit_ready_o), 32'd1);

    // Basic three-literal clause
    cl_n = 3;
    cl_var[0] = 1; cl_pol[0] = 1; cl_var[1] = 3; cl_pol[1] = 0; cl_var[2] = 5; cl_pol[2] = 1;
    run_clause();
    // Duplicate literal not counted
    cl_var[0] = 2; cl_pol[0] = 1; cl_var[1] = 2; cl_pol[1] = 1; cl_var[2] = 6; cl_pol[2] = 0;
    run_clause();
    // Tautology, then single-literal clause
    cl_n = 2;
    cl_var[0] = 4; cl_pol[0] = 1; cl_var[1] = 4; cl_pol[1] = 0;
    run_clause();
    cl_n = 1;
    cl_var[0] = 0; cl_pol[0] = 0;
    run_clause();
    // Out-of-range index
    cl_n = 3;
    cl_var[0] = 1; cl_pol[0] = 1; cl_var[1] = 9; cl_pol[1] = 0; cl_var[2] = 2; cl_pol[2] = 1;
    run_clause();

    // Abort discards buffered literals and the simultaneous one
    send(1, 1, 0);
    send(2, 1, 0);
    lif.lit_valid_i = 1'b1; lif.lit_var_i = 4'd3; lif.lit_pol_i = 1'b1;
    lif.lit_last_i  = 1'b1; lif.abort_i = 1'b1;
    @(negedge clk);
    idle();
    chk("abort_len", 32'(lif.clause_len_o), 32'd0);
    cl_n = 1;
    cl_var[0] = 7; cl_pol[0] = 1;
    run_clause();

    // Valid held through EMIT: the next literal waits and is not lost
    send(4, 0, 0);
    send(6, 1, 1);
    chk("hold_wr", 32'(lif.wr_o), 32'd1);
    chk("hold_len", 32'(lif.clause_len_o), 32'd2);
    lif.lit_valid_i = 1'b1; lif.lit_var_i = 4'd0; lif.lit_pol_i = 1'b1; lif.lit_last_i = 1'b1;
    chk("hold_ready_emit", 32'(lif.lit_ready_o), 32'd0);
    @(negedge clk);
    chk("hold_ready_collect", 32'(lif.lit_ready_o), 32'd1);
    @(negedge clk);
    idle();
    chk("hold_wr2", 32'(lif.wr_o), 32'd1);
    chk("hold_len2", 32'(lif.clause_len_o), 32'd1);
    chk("hold_vec2", 32'(lif.var_value_o), 32'h4);
    exp_cnt = (exp_cnt + 2) % (1 << CW);
    @(negedge clk);
    chk("hold_cnt", 32'(cnt), 32'(exp_cnt));

    // Random clauses, including some out-of-range indices
    for (int k = 0; k < 40; k++) begin
      cl_n = int'($urandom_range(1, 6));
      for (int i = 0; i < cl_n; i++) begin
        cl_var[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15))
                                                 : int'($urandom_range(0, 7));
        cl_pol[i] = bit'($urandom_range(0, 1));
      end
      run_clause();
    end

    // Reset with two literals buffered
    send(1, 1, 0);
    send(5, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_wr", 32'(lif.wr_o), 32'd0);
    chk("mrst_vec", 32'(lif.var_value_o), 32'd0);
    chk("mrst_len", 32'(lif.clause_len_o), 32'd0);
    chk("mrst_cnt", 32'(cnt), 32'd0);
    rst = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    chk("mrst_ready", 32'(lif.lit_ready_o), 32'd1);
    cl_n = 1;
    cl_var[0] = 5; cl_pol[0] = 1;
    run_clause();

    // Counter wrap: a full counter period of accepted clauses returns to the start value
    start_cnt = exp_cnt;
    for (int k = 0; k < (1 << CW); k++) begin
      cl_n = 1;
      cl_var[0] = int'($urandom_range(0, 7));
      cl_pol[0] = bit'($urandom_range(0, 1));
      run_clause();
    end
    chk("cnt_wrap", 32'(cnt), 32'(start_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
